// File: rtl/spi_io_expander_pkg.sv
// spi_io_expander_pkg: register map regions, command layout and frame states
package spi_io_expander_pkg;
    localparam logic [2:0] REG_OUT   = 3'h0;
    localparam logic [2:0] REG_DIR   = 3'h1;
    localparam logic [2:0] REG_IN    = 3'h2;
    localparam logic [2:0] REG_IMASK = 3'h3;
    localparam logic [2:0] REG_ISTAT = 3'h4;
    localparam int RW_BIT = 7;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
endpackage

// File: rtl/spi_io_expander_if.sv
// spi_io_expander_if: SPI pin bundle between a bus master and the expander
interface spi_io_expander_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;
    modport master (output ss, sclk, mosi, input miso, miso_oe);
    modport slave (input ss, sclk, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_io_expander_frontend.sv
// spi_frontend: oversampled SPI pins, sclk edge detect and byte-wide rx/tx shifting
module spi_frontend #(
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       active,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic sclk_prev, armed, lead, trail, sample, shift;
    logic [2:0] cnt;
    logic [6:0] rx;
    logic [7:0] tx;

    // armed stays low until ss is seen high, so a frame cut by reset is never resumed
    assign active = armed & ~ss_sync[SYNC_STAGES-1];
    assign lead = sclk_sync[SYNC_STAGES-1] != sclk_prev && sclk_sync[SYNC_STAGES-1] != 1'(CPOL);
    assign trail = sclk_sync[SYNC_STAGES-1] != sclk_prev && sclk_sync[SYNC_STAGES-1] == 1'(CPOL);
    assign sample = CPHA != 0 ? trail : lead;
    assign shift = CPHA != 0 ? lead : trail;
    assign byte_data = {rx, mosi_sync[SYNC_STAGES-1]};
    assign byte_valid = active && sample && cnt == 3'd7;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sync <= '0;
            sclk_sync <= {SYNC_STAGES{1'(CPOL)}};
            mosi_sync <= '0;
            sclk_prev <= 1'(CPOL);
            armed <= 1'b0;
            cnt <= '0;
            rx <= '0;
            tx <= '0;
            miso <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            armed <= armed | ss_sync[SYNC_STAGES-1];
            if (!active) begin
                cnt <= '0;
                rx <= '0;
                tx <= '0;
                miso <= 1'b0;
            end else begin
                if (sample) begin
                    rx <= byte_data[6:0];
                    cnt <= cnt + 3'd1;
                end
                if (tx_load)
                    tx <= tx_byte;
                else if (shift)
                    {miso, tx} <= {tx, 1'b0};
            end
        end
    end
endmodule

// File: rtl/spi_io_expander.sv
// spi_io_expander: SPI-slave GPIO expander with per-pin direction and masked pin-change irq
module spi_io_expander
    import spi_io_expander_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_io_expander_if.slave spi,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam int NB = WIDTH / 8;

    state_t state_q, state_d;
    logic active, byte_valid, tx_load, rw_q, we;
    logic [7:0] byte_data, tx_byte;
    logic [6:0] addr_q, rd_addr;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] out_q, dir_q, imask_q, istat_q, in_prev, bmask, wbits, rd_word;

    spi_frontend #(.CPOL(CPOL), .CPHA(CPHA), .SYNC_STAGES(SYNC_STAGES)) u_frontend (
        .clk(clk),
        .rst(rst),
        .ss(spi.ss),
        .sclk(spi.sclk),
        .mosi(spi.mosi),
        .tx_load(tx_load),
        .tx_byte(tx_byte),
        .miso(spi.miso),
        .active(active),
        .byte_valid(byte_valid),
        .byte_data(byte_data)
    );

    assign spi.miso_oe = active;
    assign gpio_out = out_q;
    assign gpio_oe = dir_q;

    always_comb begin
        state_d = !active ? IDLE : state_q == IDLE ? CMD : state_q == CMD && byte_valid ? DATA : state_q;
        we = state_q == DATA && byte_valid && rw_q;
        tx_load = byte_valid && state_q != IDLE;
        // the next byte out is fetched while the current one completes
        rd_addr = state_q == CMD ? byte_data[6:0] : addr_q + 7'd1;
        for (int b = 0; b < NB; b++)
            bmask[8*b +: 8] = {8{addr_q[3:0] == 4'(b)}};
        wbits = {NB{byte_data}} & bmask;
        rd_word = rd_addr[6:4] == REG_OUT ? out_q :
                  rd_addr[6:4] == REG_DIR ? dir_q :
                  rd_addr[6:4] == REG_IN ? in_sync[SYNC_STAGES-1] :
                  rd_addr[6:4] == REG_IMASK ? imask_q :
                  rd_addr[6:4] == REG_ISTAT ? istat_q : '0;
        tx_byte = rd_addr[3:0] < 4'(NB) ? 8'(rd_word >> {rd_addr[3:0], 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rw_q <= 1'b0;
            addr_q <= '0;
            out_q <= '0;
            dir_q <= '0;
            imask_q <= '0;
            istat_q <= '0;
            in_sync <= '0;
            in_prev <= '0;
            irq <= 1'b0;
        end else begin
            state_q <= state_d;
            in_sync <= {in_sync[SYNC_STAGES-2:0], gpio_in};
            in_prev <= in_sync[SYNC_STAGES-1];
            if (state_q == CMD && byte_valid) begin
                rw_q <= byte_data[RW_BIT];
                addr_q <= byte_data[6:0];
            end
            if (state_q == DATA && byte_valid)
                addr_q <= addr_q + 7'd1;
            out_q <= we && addr_q[6:4] == REG_OUT ? (out_q & ~bmask) | wbits : out_q;
            dir_q <= we && addr_q[6:4] == REG_DIR ? (dir_q & ~bmask) | wbits : dir_q;
            imask_q <= we && addr_q[6:4] == REG_IMASK ? (imask_q & ~bmask) | wbits : imask_q;
            // set is ORed in after the clear so a coincident pin change wins
            istat_q <= (istat_q & ~(we && addr_q[6:4] == REG_ISTAT ? wbits : '0)) | (in_sync[SYNC_STAGES-1] ^ in_prev);
            irq <= |(istat_q & imask_q);
        end
    end
endmodule

// File: tb/tb_spi_io_expander.sv
// tb_spi_io_expander: randomized register traffic on a mode-0 16-bit and a mode-3 8-bit expander
module tb_spi_io_expander;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_io_expander_if sa();
    spi_io_expander_if sb();
    logic ss_v [2];
    logic sclk_v [2];
    logic mosi_v [2];
    assign sa.ss = ss_v[0];
    assign sa.sclk = sclk_v[0];
    assign sa.mosi = mosi_v[0];
    assign sb.ss = ss_v[1];
    assign sb.sclk = sclk_v[1];
    assign sb.mosi = mosi_v[1];

    logic [15:0] gin_a, gout_a, goe_a;
    logic [7:0] gin_b, gout_b, goe_b;
    logic irq_a, irq_b;

    spi_io_expander #(.WIDTH(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .spi(sa), .gpio_in(gin_a), .gpio_out(gout_a), .gpio_oe(goe_a), .irq(irq_a)
    );
    spi_io_expander #(.WIDTH(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) u_b (
        .clk(clk), .rst(rst), .spi(sb), .gpio_in(gin_b), .gpio_out(gout_b), .gpio_oe(goe_b), .irq(irq_b)
    );

    logic [15:0] m_out [2];
    logic [15:0] m_dir [2];
    logic [15:0] m_imask [2];
    logic [15:0] m_istat [2];
    int nb [2] = '{2, 1};
    logic [7:0] txb [8];
    logic [7:0] rxb [8];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] wmask(input int d);
        return d == 1 ? 16'h00ff : 16'hffff;
    endfunction

    function automatic logic [15:0] gin(input int d);
        return d == 1 ? {8'h00, gin_b} : gin_a;
    endfunction

    function automatic logic miso(input int d);
        return d == 1 ? sb.miso : sa.miso;
    endfunction

    function automatic logic miso_oe(input int d);
        return d == 1 ? sb.miso_oe : sa.miso_oe;
    endfunction

    function automatic logic [7:0] m_read(input int d, input logic [6:0] a);
        logic [15:0] v;
        int b = int'(a[3:0]);
        case (a[6:4])
            3'd0: v = m_out[d];
            3'd1: v = m_dir[d];
            3'd2: v = gin(d);
            3'd3: v = m_imask[d];
            3'd4: v = m_istat[d];
            default: v = 16'h0000;
        endcase
        return b < nb[d] ? v[8*b +: 8] : 8'h00;
    endfunction

    task automatic m_write(input int d, input logic [6:0] a, input logic [7:0] data);
        int b = int'(a[3:0]);
        logic [15:0] m = 16'h00ff << (8 * b);
        logic [15:0] w = {data, data} & m;
        if (b >= nb[d]) return;
        case (a[6:4])
            3'd0: m_out[d] = (m_out[d] & ~m) | w;
            3'd1: m_dir[d] = (m_dir[d] & ~m) | w;
            3'd3: m_imask[d] = (m_imask[d] & ~m) | w;
            3'd4: m_istat[d] = m_istat[d] & ~w;
            default: ;
        endcase
    endtask

    task automatic set_gin(input int d, input logic [15:0] v);
        m_istat[d] = m_istat[d] | ((gin(d) ^ v) & wmask(d));
        if (d == 1) gin_b = v[7:0];
        else gin_a = v;
    endtask

    task automatic chk_outs(input int d);
        chk($sformatf("gpio_out d%0d", d), d == 1 ? {8'h00, gout_b} : gout_a, m_out[d]);
        chk($sformatf("gpio_oe d%0d", d), d == 1 ? {8'h00, goe_b} : goe_a, m_dir[d]);
        chk($sformatf("irq d%0d", d), d == 1 ? irq_b : irq_a, |(m_istat[d] & m_imask[d]));
    endtask

    // master side of one frame; tog flips gpio_in on the sample edge of bit tog_bit
    task automatic frame(input int d, input int nbits, input bit keep, input int tog_bit, input logic [15:0] tog);
        logic pol = d == 1;
        ss_v[d] = 1'b0;
        wt(H);
        chk($sformatf("miso_oe active d%0d", d), miso_oe(d), 1);
        for (int k = 0; k < nbits; k++) begin
            int j = k / 8;
            int i = 7 - k % 8;
            if (d == 0) begin
                mosi_v[d] = txb[j][i];
                wt(H);
                rxb[j][i] = miso(d);
                sclk_v[d] = ~pol;
                if (k == tog_bit) gin_a ^= tog;
                wt(H);
                sclk_v[d] = pol;
            end else begin
                sclk_v[d] = ~pol;
                mosi_v[d] = txb[j][i];
                wt(H);
                rxb[j][i] = miso(d);
                sclk_v[d] = pol;
                if (k == tog_bit) gin_b ^= tog[7:0];
                wt(H);
            end
        end
        if (!keep) begin
            wt(H);
            ss_v[d] = 1'b1;
            wt(4 * H);
            chk($sformatf("miso_oe idle d%0d", d), miso_oe(d), 0);
            chk($sformatf("miso idle d%0d", d), miso(d), 0);
        end
    endtask

    task automatic xfer(input int d, input int nbytes, input logic [15:0] tog);
        logic [6:0] a = txb[0][6:0];
        frame(d, 8 * nbytes, 1'b0, tog != 0 ? 8 * nbytes - 1 : -1, tog);
        chk($sformatf("cmd miso d%0d", d), rxb[0], 0);
        for (int j = 1; j < nbytes; j++) begin
            if (!txb[0][7]) chk($sformatf("read d%0d a%02h", d, a), rxb[j], m_read(d, a));
            else m_write(d, a, txb[j]);
            a = a + 7'd1;
        end
        m_istat[d] = m_istat[d] | (tog & wmask(d));
        chk_outs(d);
    endtask

    initial begin
        int lat;
        ss_v = '{1'b1, 1'b1};
        sclk_v = '{1'b0, 1'b1};
        mosi_v = '{1'b0, 1'b0};
        gin_a = '0;
        gin_b = '0;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = '0;
            m_dir[d] = '0;
            m_imask[d] = '0;
            m_istat[d] = '0;
        end
        wt(5);
        for (int d = 0; d < 2; d++) begin
            chk_outs(d);
            chk($sformatf("rst miso d%0d", d), miso(d), 0);
            chk($sformatf("rst miso_oe d%0d", d), miso_oe(d), 0);
        end
        rst = 1'b1;
        wt(10);

        txb[0] = 8'h80; txb[1] = 8'hA5;
        xfer(0, 2, '0);
        txb[0] = 8'h90; txb[1] = 8'hFF;
        xfer(0, 2, '0);
        chk("out lo A5", gout_a[7:0], 8'hA5);
        chk("oe lo FF", goe_a[7:0], 8'hFF);

        txb[0] = 8'h80; txb[1] = 8'h12; txb[2] = 8'h34;
        xfer(0, 3, '0);
        chk("burst out", gout_a, 16'h3412);
        set_gin(0, 16'hBEEF);
        wt(8);
        txb[0] = 8'h20; txb[1] = 8'h00; txb[2] = 8'h00;
        xfer(0, 3, '0);
        chk("in byte0", rxb[1], 8'hEF);
        chk("in byte1", rxb[2], 8'hBE);

        txb[0] = 8'h90; txb[1] = 8'h5A;
        xfer(1, 2, '0);
        txb[0] = 8'h10; txb[1] = 8'h00;
        xfer(1, 2, '0);
        chk("mode3 cmd", rxb[0], 8'h00);
        chk("mode3 dir", rxb[1], 8'h5A);

        txb[0] = 8'hC0; txb[1] = 8'hFF; txb[2] = 8'hFF;
        xfer(0, 3, '0);
        txb[0] = 8'hB0; txb[1] = 8'h01;
        xfer(0, 2, '0);
        set_gin(0, gin_a ^ 16'h0001);
        lat = -1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (irq_a && lat < 0) lat = c;
        end
        chk("irq latency", lat > 0 && lat <= 5, 1);
        wt(4);
        txb[0] = 8'hC0; txb[1] = 8'h01;
        xfer(0, 2, '0);
        chk("irq w1c", irq_a, 0);
        set_gin(0, gin_a ^ 16'h0001);
        wt(8);
        chk("irq reset", irq_a, 1);
        xfer(0, 2, 16'h0001);
        chk("irq set wins", irq_a, 1);

        txb[0] = 8'h80; txb[1] = 8'hFF;
        frame(0, 13, 1'b0, -1, '0);
        chk_outs(0);
        txb[0] = 8'h80; txb[1] = 8'h3C;
        xfer(0, 2, '0);

        for (int it = 0; it < 24; it++) begin
            int d = int'($urandom_range(0, 1));
            int op = int'($urandom_range(0, 3));
            if (op == 0) begin
                set_gin(d, 16'($urandom));
                wt(8);
                chk_outs(d);
            end else begin
                int n = int'($urandom_range(2, 4));
                logic [2:0] r = 3'($urandom_range(0, 5));
                logic [6:0] a = r == 3'd5 ? 7'($urandom_range(8'h50, 8'h7F)) : {r, 4'($urandom_range(0, 2))};
                txb[0] = {op != 1, a};
                for (int j = 1; j < n; j++) txb[j] = 8'($urandom);
                xfer(d, n, '0);
            end
        end

        txb[0] = 8'h80; txb[1] = 8'hFF; txb[2] = 8'hFF;
        xfer(0, 3, '0);
        txb[0] = 8'h80; txb[1] = 8'hAA;
        xfer(1, 2, '0);
        set_gin(0, '0);
        set_gin(1, '0);
        wt(8);
        txb[0] = 8'h80; txb[1] = 8'h77;
        frame(0, 11, 1'b1, -1, '0);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = '0;
            m_dir[d] = '0;
            m_imask[d] = '0;
            m_istat[d] = '0;
            chk_outs(d);
        end
        chk("async rst miso_oe", sa.miso_oe, 0);
        chk("async rst miso", sa.miso, 0);
        wt(2);
        ss_v[0] = 1'b1;
        sclk_v[0] = 1'b0;
        wt(3);
        rst = 1'b1;
        wt(10);
        txb[0] = 8'h00; txb[1] = 8'h00;
        xfer(0, 2, '0);
        chk("read after rst", rxb[1], 8'h00);
        txb[0] = 8'h80; txb[1] = 8'hC3;
        xfer(0, 2, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
